vga_timing_gen: RTL

- Raster timing source for the VGA peripheral. Produces the pixel_row/pixel_column coordinates consumed by all sprite and overlay generators, plus hsync, vsync and video_on for the DAC/connector.
- Default mode is 640x480 @ 72 Hz from the 31.5 MHz pixel clock.
- Provides a per-frame pulse so sprite motion can be frame-locked rather than free-running on clock counts.
- Provides a programmable sync/blank delay line to match downstream pixel pipeline latency.

---
 rtl/vga_timing_pkg.sv | 39 +++
 rtl/sync_delay_line.sv | 33 +++
 rtl/vga_timing_gen.sv | 99 +++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster constants and types for the VGA timing source.
// Default mode is 640x480 @ 72 Hz from a 31.5 MHz pixel clock.
package vga_timing_pkg;

  localparam int unsigned COORD_W   = 12;
  localparam int unsigned COORD_MAX = 4095;

  typedef logic [COORD_W-1:0] coord_t;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 24;
  localparam int unsigned DEF_H_SYNC    = 40;
  localparam int unsigned DEF_H_BACK    = 128;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 9;
  localparam int unsigned DEF_V_SYNC    = 3;
  localparam int unsigned DEF_V_BACK    = 28;

  localparam int unsigned DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int unsigned PIPE_DELAY_MAX = 7;

  // Other modes that also run from a 31.5 MHz pixel clock:
  //   640x480 @ 75 Hz : H 640/16/64/120 (840), V 480/1/3/16 (500), both active-low
  //   640x350 @ 85 Hz variants need 31.5 MHz with H 640/32/64/96 (832), V 350/32/3/60 (445)

  // Flags carried through the delay line, packed in output order
  typedef struct packed {
    logic video_on;
    logic hsync;
    logic vsync;
  } sync_flags_t;

  function automatic logic in_range(coord_t x, int unsigned lo, int unsigned hi);
    return (x >= COORD_W'(lo)) && (x < COORD_W'(hi));
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Resettable shift register aligning sync/blank flags with downstream pixel latency.
module sync_delay_line #(
  parameter int unsigned     WIDTH   = 3,
  parameter int unsigned     DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign q = d;
  end else begin : g_shift
    localparam int unsigned SR_W = DEPTH * WIDTH;
    logic [SR_W-1:0] sr;

    // Newest sample enters at the bottom; the oldest falls off the top
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sr <= {DEPTH{RST_VAL}};
      end else begin
        sr <= SR_W'({sr, d});
      end
    end

    assign q = sr[SR_W-1 -: WIDTH];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters plus sync/blank generation with a programmable flag delay.
// Flags are derived from the next count so they land in step with the coordinates.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT    = DEF_H_FRONT,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BACK     = DEF_H_BACK,
  parameter int unsigned V_VISIBLE  = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT    = DEF_V_FRONT,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BACK     = DEF_V_BACK,
  parameter logic        H_POL      = 1'b0,
  parameter logic        V_POL      = 1'b0,
  parameter int unsigned PIPE_DELAY = 1
) (
  input  logic   clk,
  input  logic   rst,
  output coord_t pixel_row,
  output coord_t pixel_column,
  output logic   video_on,
  output logic   hsync,
  output logic   vsync,
  output logic   line_start,
  output logic   frame_start
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam sync_flags_t FLAGS_IDLE = '{video_on: 1'b0, hsync: ~H_POL, vsync: ~V_POL};

  if (H_TOTAL > COORD_MAX) begin : g_h_total_chk
    $error("vga_timing_gen: H_TOTAL exceeds 12-bit counter range");
  end
  if (V_TOTAL > COORD_MAX) begin : g_v_total_chk
    $error("vga_timing_gen: V_TOTAL exceeds 12-bit counter range");
  end
  if (PIPE_DELAY > PIPE_DELAY_MAX) begin : g_pipe_chk
    $error("vga_timing_gen: PIPE_DELAY must be 0..7");
  end

  coord_t      h_cnt, v_cnt;
  coord_t      h_next, v_next;
  sync_flags_t flags_d, flags_q, flags_out;

  // Next raster position and the flags that belong to it
  always_comb begin
    h_next  = h_cnt + COORD_W'(1);
    v_next  = v_cnt;
    flags_d = FLAGS_IDLE;
    if (h_cnt == COORD_W'(H_TOTAL - 1)) begin
      h_next = '0;
      v_next = (v_cnt == COORD_W'(V_TOTAL - 1)) ? '0 : v_cnt + COORD_W'(1);
    end
    flags_d.video_on = (h_next < COORD_W'(H_VISIBLE)) && (v_next < COORD_W'(V_VISIBLE));
    flags_d.hsync    = in_range(h_next, HS_START, HS_END) ? H_POL : ~H_POL;
    flags_d.vsync    = in_range(v_next, VS_START, VS_END) ? V_POL : ~V_POL;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      flags_q     <= FLAGS_IDLE;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_cnt       <= h_next;
      v_cnt       <= v_next;
      flags_q     <= flags_d;
      line_start  <= (h_next == '0);
      frame_start <= (h_next == '0) && (v_next == '0);
    end
  end

  sync_delay_line #(
    .WIDTH  ($bits(sync_flags_t)),
    .DEPTH  (PIPE_DELAY),
    .RST_VAL(FLAGS_IDLE)
  ) u_sync_delay_line (
    .clk(clk),
    .rst(rst),
    .d  (flags_q),
    .q  (flags_out)
  );

  assign pixel_row    = v_cnt;
  assign pixel_column = h_cnt;
  assign video_on     = flags_out.video_on;
  assign hsync        = flags_out.hsync;
  assign vsync        = flags_out.vsync;

endmodule
